// File: rtl/riscv_sim_monitor_pkg.sv
// Shared definitions for the RV32I run monitor: state encodings, tohost
// address default and the pass/fail value convention written by test code.
// Imported by riscv_sim_monitor and riscv_store_signature.
package riscv_sim_monitor_pkg;

  // Monitor state; every non-RUN value is terminal until reset.
  typedef enum logic [2:0] {
    MON_RUN     = 3'd0,
    MON_PASS    = 3'd1,
    MON_FAIL    = 3'd2,
    MON_TIMEOUT = 3'd3,
    MON_HANG    = 3'd4
  } monState_t;

  // Word the test program writes to report its result.
  localparam logic [31:0] TOHOST_ADDR_DEF = 32'h0000_0FFC;

  // tohost convention: 1 = pass, other odd value = (code << 1) | 1, even = ignored.
  localparam int          TOHOST_PASS_VAL = 1;

  // Only a full-word store to tohost reports a result.
  localparam logic [3:0]  BYTE_SEL_FULL   = 4'b1111;

endpackage

// File: rtl/riscv_store_signature.sv
// Store signature accumulator: sig <= rotl1(sig) ^ addr ^ (wdata with unselected bytes zeroed).
// Latency: one cycle from an enabled store to the updated o_sig.
// Backpressure: none; samples every enabled cycle, async clear on i_rstn low.
// Ports: i_clk, i_rstn, i_en (accumulate this cycle), i_byte_sel, i_addr,
//        i_wdata (store bus), o_sig (registered running signature).
module riscv_store_signature
  import riscv_sim_monitor_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            i_clk,
  input  logic            i_rstn,
  input  logic            i_en,
  input  logic [3:0]      i_byte_sel,
  input  logic [XLEN-1:0] i_addr,
  input  logic [XLEN-1:0] i_wdata,
  output logic [XLEN-1:0] o_sig
);

  logic [XLEN-1:0] maskedData;

  // Byte lanes not written by the store must not leak stale bus data into the signature.
  always_comb begin
    maskedData = '0;
    for (int i = 0; i < 4; i++) begin
      if (i_byte_sel[i]) begin
        maskedData[8*i +: 8] = i_wdata[8*i +: 8];
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      o_sig <= '0;
    end else if (i_en) begin
      o_sig <= {o_sig[XLEN-2:0], o_sig[XLEN-1]} ^ i_addr ^ maskedData;
    end
  end

endmodule

// File: rtl/riscv_sim_monitor.sv
// Run monitor for the pipelined RV32I core: tohost pass/fail, cycle timeout, fetch hang, store signature.
// Latency: every output reflects the input sampled on the previous rising edge.
// Backpressure: none; pure observer, inputs sampled only in RUN, terminal states sticky until reset.
// Ports: i_clk, i_rstn; snooped i_pcF, i_mem_wr_enM, i_mem_byte_selM, i_mem_addrM, i_mem_wdataM;
//        status o_state, o_done, o_pass, o_fail_code, o_cycle_cnt, o_store_cnt, o_signature.
module riscv_sim_monitor
  import riscv_sim_monitor_pkg::*;
#(
  parameter int          XLEN        = 32,
  parameter logic [31:0] TOHOST_ADDR = TOHOST_ADDR_DEF,
  parameter int          MAX_CYCLES  = 200,
  parameter int          HANG_CYCLES = 16,
  parameter int          CNT_W       = 32
) (
  input  logic             i_clk,
  input  logic             i_rstn,
  input  logic [XLEN-1:0]  i_pcF,
  input  logic             i_mem_wr_enM,
  input  logic [3:0]       i_mem_byte_selM,
  input  logic [XLEN-1:0]  i_mem_addrM,
  input  logic [XLEN-1:0]  i_mem_wdataM,
  output logic [2:0]       o_state,
  output logic             o_done,
  output logic             o_pass,
  output logic [XLEN-2:0]  o_fail_code,
  output logic [CNT_W-1:0] o_cycle_cnt,
  output logic [CNT_W-1:0] o_store_cnt,
  output logic [XLEN-1:0]  o_signature
);

  localparam int               HANG_W     = $clog2(HANG_CYCLES) + 1;
  localparam logic [HANG_W-1:0] HANG_LIMIT = HANG_W'(HANG_CYCLES - 1);
  localparam logic [CNT_W-1:0]  CYC_LIMIT  = CNT_W'(MAX_CYCLES);

  monState_t         state, stateNext;
  logic [CNT_W-1:0]  cycleCnt, cycleNext;
  logic [CNT_W-1:0]  storeCnt;
  logic [XLEN-2:0]   failCode;
  logic [XLEN-1:0]   pcRef;
  logic              pcRefVld;
  logic [HANG_W-1:0] hangCnt, hangNext;

  logic isStore, toTohost, tohostResult, ordStore, isPassVal, hangHit, running;

  assign running      = (state == MON_RUN);
  assign isStore      = i_mem_wr_enM && (i_mem_byte_selM != 4'b0000);
  assign toTohost     = isStore && (i_mem_addrM == XLEN'(TOHOST_ADDR)) &&
                        (i_mem_byte_selM == BYTE_SEL_FULL);
  // Even tohost values are neither a result nor an ordinary store.
  assign tohostResult = toTohost && i_mem_wdataM[0];
  assign isPassVal    = (i_mem_wdataM == XLEN'(TOHOST_PASS_VAL));
  // Partial-width writes to the tohost address are plain data stores.
  assign ordStore     = isStore && !toTohost;
  assign cycleNext    = cycleCnt + 1'b1;

  // The first RUN sample after reset only loads the reference PC.
  assign hangNext = (pcRefVld && (i_pcF == pcRef)) ? hangCnt + 1'b1 : '0;
  assign hangHit  = pcRefVld && (i_pcF == pcRef) && (hangNext == HANG_LIMIT);

  // Priority: tohost result > timeout > hang.
  always_comb begin
    stateNext = state;
    if (running) begin
      if (tohostResult && isPassVal) begin
        stateNext = MON_PASS;
      end else if (tohostResult) begin
        stateNext = MON_FAIL;
      end else if (cycleNext == CYC_LIMIT) begin
        stateNext = MON_TIMEOUT;
      end else if (hangHit) begin
        stateNext = MON_HANG;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state    <= MON_RUN;
      cycleCnt <= '0;
      storeCnt <= '0;
      failCode <= '0;
      pcRef    <= '0;
      pcRefVld <= 1'b0;
      hangCnt  <= '0;
    end else begin
      state <= stateNext;
      if (running) begin
        cycleCnt <= cycleNext;
        pcRef    <= i_pcF;
        pcRefVld <= 1'b1;
        hangCnt  <= hangNext;
        // Still counted when the same edge enters TIMEOUT or HANG.
        if (ordStore && (storeCnt != '1)) begin
          storeCnt <= storeCnt + 1'b1;
        end
        if (tohostResult && !isPassVal) begin
          failCode <= i_mem_wdataM[XLEN-1:1];
        end
      end
    end
  end

  riscv_store_signature #(
    .XLEN(XLEN)
  ) uSig (
    .i_clk      (i_clk),
    .i_rstn     (i_rstn),
    .i_en       (running && ordStore),
    .i_byte_sel (i_mem_byte_selM),
    .i_addr     (i_mem_addrM),
    .i_wdata    (i_mem_wdataM),
    .o_sig      (o_signature)
  );

  assign o_state     = state;
  assign o_done      = (state != MON_RUN);
  assign o_pass      = (state == MON_PASS);
  assign o_fail_code = failCode;
  assign o_cycle_cnt = cycleCnt;
  assign o_store_cnt = storeCnt;

endmodule
